// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter control unit.
package pc_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_REL,
        SEL_RAS,
        SEL_HOLD
    } sel_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry.
// The ovf/unf flags are sticky and cleared only by reset.
module return_addr_stack
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty,
    output logic            ovf,
    output logic            unf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PC_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[ptr_q - PTR_W'(1)];
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    // ptr_q is the next write slot; the newest entry sits just below it.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            mem_d[ptr_q] = din;
            ptr_d        = ptr_q + PTR_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

endmodule

// File: rtl/pc_control_unit.sv
// PC register, RUN/HALT FSM and prioritized next-PC selection
// (halt > ret > call > jump > branch > sequential).
module pc_control_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        halt,
    input  logic        resume,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        call,
    input  logic        ret,
    input  logic [31:0] imm32,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        halted,
    output logic        ras_ovf,
    output logic        ras_unf
);

    state_e          state_q, state_d;
    sel_e            sel;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_seq, pc_rel;
    logic            ras_push, ras_pop;
    logic [PC_W-1:0] ras_dout;
    logic            ras_full, ras_empty;

    assign pc_seq = pc_q + PC_STEP;
    assign pc_rel = pc_q + (imm32 & 32'hFFFF_FFFC);

    return_addr_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (ras_push),
        .pop  (ras_pop),
        .din  (pc_seq),
        .dout (ras_dout),
        .full (ras_full),
        .empty(ras_empty),
        .ovf  (ras_ovf),
        .unf  (ras_unf)
    );

    // Priority encoder and FSM next state; a stalled RUN holds everything.
    always_comb begin
        state_d  = state_q;
        sel      = SEL_HOLD;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (en) begin
                    if (halt) begin
                        sel     = SEL_SEQ;
                        state_d = HALT;
                    end else if (ret) begin
                        ras_pop = 1'b1;
                        sel     = ras_empty ? SEL_SEQ : SEL_RAS;
                    end else if (call) begin
                        ras_push = 1'b1;
                        sel      = SEL_REL;
                    end else if (jump || br_taken) begin
                        sel = SEL_REL;
                    end else begin
                        sel = SEL_SEQ;
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            SEL_SEQ:  pc_d = pc_seq;
            SEL_REL:  pc_d = pc_rel;
            SEL_RAS:  pc_d = ras_dout;
            SEL_HOLD: pc_d = pc_q;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == RUN);
    assign halted   = (state_q == HALT);

    // Occupancy can never be both zero and at capacity.
    a_full_empty_excl: assert property (@(posedge clk) disable iff (rst)
        !(ras_full && ras_empty));

endmodule

// File: doc/pc_control_unit.md
# pc_control_unit

Program-counter and next-PC unit for the single-cycle RISC core. Holds the architectural PC and selects the next PC each cycle from sequential fall-through, PC-relative branch/jump targets, call and return. It consumes the 32-bit sign-extended offset produced by the immediate sign-extension stage. A small return-address stack and a RUN/HALT state machine control fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `RAS_DEPTH`, default 4: return-address stack entries; must be a power of two and at least 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 = stall, no architectural state changes.
- `halt`  in  1  current instruction is HALT.
- `resume`  in  1  leave the HALT state.
- `br_taken`  in  1  conditional branch resolved taken.
- `jump`  in  1  unconditional PC-relative jump.
- `call`  in  1  PC-relative jump that also pushes the return address.
- `ret`  in  1  return to the address on top of the stack.
- `imm32`  in  32  sign-extended byte offset; bits [1:0] are ignored and treated as 0.
- `pc`  out  32  current PC, i.e. the fetch address.
- `pc_valid`  out  1  1 when in RUN; instruction at `pc` is to be executed.
- `halted`  out  1  1 when in HALT.
- `ras_ovf`  out  1  sticky flag: a push occurred while the stack was full.
- `ras_unf`  out  1  sticky flag: a pop occurred while the stack was empty.

## Operation
- **States.**
  - RUN: `pc_valid`=1, `halted`=0.
  - HALT: `pc_valid`=0, `halted`=1.
- **RUN with `en`=1.** Exactly one action is taken, by priority: `halt` > `ret` > `call` > `jump` > `br_taken` > sequential. Lower-priority requests in the same cycle are dropped.
  - halt: `pc` <= `pc`+4; go to HALT.
  - ret:
    - If the stack is non-empty: `pc` <= popped entry.
    - If the stack is empty: `pc` <= `pc`+4, and set `ras_ovf`'s counterpart `ras_unf`.
  - call: push `pc`+4, then `pc` <= `pc`+`imm32`.
  - jump / br_taken: `pc` <= `pc`+`imm32`.
  - sequential: `pc` <= `pc`+4.
- **RUN with `en`=0.** `pc`, the stack and the flags hold. Control inputs are ignored.
- **HALT.** `pc` and the stack hold. `resume`=1 moves to RUN on the next edge, regardless of `en`. All other inputs are ignored.
- **Stack.**
  - Circular buffer of depth `RAS_DEPTH` with an occupancy count from 0 to `RAS_DEPTH`.
  - Push when full: overwrite the oldest entry, keep the count at `RAS_DEPTH`, set `ras_ovf`.
  - Pop when empty: the count stays 0.
- **Arithmetic.** All PC arithmetic is modulo 2^32. Wrap-around is silent; for example, 32'hFFFF_FFFC + 4 = 0. `pc`[1:0] is always 0.
- **Flags.** `ras_ovf` and `ras_unf` are cleared only by `rst`.

## Timing
- On reset: `pc`=`RESET_PC`, state RUN, `pc_valid`=1, `halted`=0, stack empty, `ras_ovf`=0, `ras_unf`=0.
- Reset is asynchronous and takes effect mid-cycle. An in-flight call or ret is discarded.
- Latency: inputs sampled at edge N take effect on `pc` immediately after edge N. Redirects have no delay slot.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.
- A push and a pop never occur in the same cycle, because of the priority order.
- Return address on top of stack after a call sampled at edge N is the old `pc`+4. A ret at edge N+1 returns to it.

## Structure
- **Package `pc_pkg`:**
  - state enum {RUN, HALT};
  - next-PC select enum {SEL_SEQ, SEL_REL, SEL_RAS, SEL_HOLD};
  - constant `PC_STEP`=4.
- **Sub-module `return_addr_stack`:** parameter `DEPTH`; ports `push`, `pop`, `din[31:0]`, `dout[31:0]`, `full`, `empty`, `ovf`, `unf`. The sticky flags live inside it.
- **Top level:** FSM, priority encoder, next-PC mux, PC register.

## Test plan
- **Reset and sequential:** release `rst`, `en`=1, no controls, 3 cycles -> `pc` = 0, 4, 8, 12; `pc_valid`=1.
- **Branch and stall:**
  - At `pc`=0x100, `br_taken`=1, `imm32`=0xFFFF_FFF0 -> `pc`=0xF0.
  - `jump` with `imm32`=0x13 at `pc`=0xF0 -> `pc`=0x100 (low bits ignored).
  - `en`=0 with `jump` asserted -> `pc` holds.
- **Call/return:**
  - Call at 0x40 with `imm32`=0x100 -> `pc`=0x140.
  - Nested call at 0x140 with `imm32`=0x20 -> `pc`=0x160.
  - Two rets -> `pc`=0x144, then 0x44; `ras_unf`=0.
- **Stack boundaries:**
  - 5 calls with `RAS_DEPTH`=4 -> `ras_ovf`=1; 4 rets return newest-first; the oldest return address is lost.
  - A 5th ret -> `pc`=`pc`+4 and `ras_unf`=1.
- **Halt:**
  - `halt` at `pc`=0x20 together with `ret` -> `pc`=0x24, `halted`=1, `pc_valid`=0; the stack is unchanged.
  - 3 idle cycles -> no change.
  - `resume` with `en`=0 -> RUN next cycle, `pc`=0x24.
- **Wrap and async reset:**
  - `pc`=0xFFFF_FFFC sequential -> 0.
  - Assert `rst` mid-cycle during a call -> `pc`=`RESET_PC` immediately; the stack is empty and both flags are 0.
